stopwatch2: RTL and testbench

Hours/minutes/seconds stopwatch with pause, single-slot lap record and an hourly chime pulse. A parameterised prescaler derives a one-second tick from the system clock; cascaded mod-60/mod-60/mod-24 counters hold the running time. It sits between the board clock/button inputs and the display/decoder logic, which consumes the binary time fields.

---
 rtl/stopwatch2_pkg.sv | 19 +
 rtl/stopwatch2_pulse_catch.sv | 50 +++++
 rtl/stopwatch2.sv | 102 ++++++++++
 tb/tb_stopwatch2.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/stopwatch2_pkg.sv
// rtl/stopwatch2_pkg.sv - field widths, limits and time record type for stopwatch2
`timescale 1ns/1ps
package stopwatch2_pkg;

  localparam int SEC_W  = 7;
  localparam int MIN_W  = 7;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 7'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 7'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } time_t;

endpackage

// File: rtl/stopwatch2_pulse_catch.sv
// rtl/stopwatch2_pulse_catch.sv - catches any record rising edge, syncs it into clk
// and returns a one-cycle capture strobe; the strobe also clears the catch flop.
`timescale 1ns/1ps
module stopwatch2_pulse_catch (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pulse_i,
  output logic strobe_o
);

  logic       catch_q;
  logic       sync1_q, sync2_q;
  logic       ack_q;
  logic [1:0] mask_q, mask_d;
  logic       clr_n;
  logic       strobe;

  assign clr_n = rst_ni & ~ack_q;

  always_ff @(posedge pulse_i or negedge clr_n) begin
    if (!clr_n) catch_q <= 1'b0;
    else        catch_q <= 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      ack_q   <= 1'b0;
      mask_q  <= 2'd0;
    end else begin
      sync1_q <= catch_q;
      sync2_q <= sync1_q;
      ack_q   <= strobe;
      mask_q  <= mask_d;
    end
  end

  // After an acknowledge the synchroniser still holds two stale 1s; masking
  // them means a fresh request can be told apart even if sync2 never drops.
  always_comb begin
    strobe = sync2_q && (mask_q == 2'd0);
    mask_d = mask_q;
    if (strobe)             mask_d = 2'd2;
    else if (mask_q != 2'd0) mask_d = mask_q - 2'd1;
  end

  assign strobe_o = strobe;

endmodule

// File: rtl/stopwatch2.sv
// rtl/stopwatch2.sv - h:m:s stopwatch with pause, lap record and hourly chime.
// Define STOPWATCH2_RING_EN to build the chime; otherwise ring is tied low.
`timescale 1ns/1ps
module stopwatch2
  import stopwatch2_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stop,
  input  logic              record,
  output logic              ring,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic [SEC_W-1:0]  rec_sec,
  output logic [MIN_W-1:0]  rec_min,
  output logic [HOUR_W-1:0] rec_hour
);

  localparam int            PW        = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;
  time_t         time_q, time_d;
  time_t         rec_q, rec_d;
  logic          tick;
  logic          cap;

  stopwatch2_pulse_catch u_catch (
    .clk_i    (clk),
    .rst_ni   (reset),
    .pulse_i  (record),
    .strobe_o (cap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      time_q  <= '0;
      rec_q   <= '0;
    end else begin
      presc_q <= presc_d;
      time_q  <= time_d;
      rec_q   <= rec_d;
    end
  end

  always_comb begin
    presc_d = presc_q;
    time_d  = time_q;
    tick    = 1'b0;
    if (!stop) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    if (tick) begin
      if (time_q.sec == SEC_MAX) begin
        time_d.sec = '0;
        if (time_q.min == MIN_MAX) begin
          time_d.min  = '0;
          time_d.hour = (time_q.hour == HOUR_MAX) ? '0 : time_q.hour + HOUR_W'(1);
        end else begin
          time_d.min = time_q.min + MIN_W'(1);
        end
      end else begin
        time_d.sec = time_q.sec + SEC_W'(1);
      end
    end
    // Lap takes the registered time, so a same-cycle tick never leaks in.
    rec_d = cap ? time_q : rec_q;
  end

`ifdef STOPWATCH2_RING_EN
  logic ring_q;
  logic hour_carry;

  assign hour_carry = tick && (time_q.sec == SEC_MAX) && (time_q.min == MIN_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ring_q <= 1'b0;
    else        ring_q <= hour_carry;
  end

  assign ring = ring_q;
`else
  assign ring = 1'b0;
`endif

  assign sec      = time_q.sec;
  assign min      = time_q.min;
  assign hour     = time_q.hour;
  assign rec_sec  = rec_q.sec;
  assign rec_min  = rec_q.min;
  assign rec_hour = rec_q.hour;

endmodule

// File: tb/tb_stopwatch2.sv
// tb/tb_stopwatch2.sv - directed bench for stopwatch2 with TICKS_PER_SEC=10, 10 ns clk
`timescale 1ns/1ps
module tb_stopwatch2;
  import stopwatch2_pkg::*;

`ifdef STOPWATCH2_RING_EN
  localparam int RING_ON = 1;
`else
  localparam int RING_ON = 0;
`endif

  localparam time_t T_LAST = '{hour: 5'd23, min: 7'd59, sec: 7'd59};

  logic              clk = 1'b0;
  logic              reset, stop, record;
  logic              ring;
  logic [SEC_W-1:0]  sec, rec_sec;
  logic [MIN_W-1:0]  min, rec_min;
  logic [HOUR_W-1:0] hour, rec_hour;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int   edges;
    logic stop;
    int   sec;
    int   min;
    int   hour;
    int   ring;
  } vec_t;

  vec_t vecs[10];

  stopwatch2 #(.TICKS_PER_SEC(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .stop     (stop),
    .record   (record),
    .ring     (ring),
    .sec      (sec),
    .min      (min),
    .hour     (hour),
    .rec_sec  (rec_sec),
    .rec_min  (rec_min),
    .rec_hour (rec_hour)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_record();
    #1 record = 1'b1;
    #1 record = 1'b0;
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, " hour"}, int'(hour), h);
    check({tag, " min"},  int'(min),  m);
    check({tag, " sec"},  int'(sec),  s);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{9,     1'b0, 4,  0,  0, 0};
    vecs[1] = '{1,     1'b0, 5,  0,  0, 0};
    vecs[2] = '{550,   1'b0, 0,  1,  0, 0};
    vecs[3] = '{30,    1'b1, 0,  1,  0, 0};
    vecs[4] = '{10,    1'b0, 1,  1,  0, 0};
    vecs[5] = '{35370, 1'b0, 58, 59, 0, 0};
    vecs[6] = '{10,    1'b0, 59, 59, 0, 0};
    vecs[7] = '{9,     1'b0, 59, 59, 0, 0};
    vecs[8] = '{1,     1'b0, 0,  0,  1, RING_ON};
    vecs[9] = '{1,     1'b0, 0,  0,  1, 0};

    reset = 1'b0; stop = 1'b0; record = 1'b0;
    #2 reset = 1'b1;
    #98 record = 1'b1;
    #1 record = 1'b0;
    #29;
    check("pre_reset sec", int'(sec), 1);
    check("pre_reset rec_sec", int'(rec_sec), 1);

    // Asynchronous reset mid-count, observed before any clock edge.
    #22 reset = 1'b0;
    #1;
    check("reset sec", int'(sec), 0);
    check("reset presc", int'(dut.presc_q), 0);
    check("reset rec_sec", int'(rec_sec), 0);
    check("reset ring", int'(ring), 0);
    #19 reset = 1'b1;

    #51 record = 1'b1;
    #1 record = 1'b0;
    #26 check("rec0 rec_sec", int'(rec_sec), 0);
    #10 check("edge9 sec", int'(sec), 0);
    #10 check("edge10 sec", int'(sec), 1);
    #4 record = 1'b1;
    #1 record = 1'b0;
    #15 check("rec1 early rec_sec", int'(rec_sec), 0);
    #10 check("rec1 rec_sec", int'(rec_sec), 1);
    check("rec1 running sec", int'(sec), 1);

    #210;
    check("prestop sec", int'(sec), 3);
    check("prestop presc", int'(dut.presc_q), 4);
    stop = 1'b1;
    #62 record = 1'b1;
    #1 record = 1'b0;
    #27 check("stopped rec_sec", int'(rec_sec), 3);
    #150;
    check("stopped sec", int'(sec), 3);
    check("stopped presc", int'(dut.presc_q), 4);
    #10 stop = 1'b0;
    #50 check("resume+5 sec", int'(sec), 3);
    #10 check("resume+6 sec", int'(sec), 4);

    for (int i = 0; i < 10; i++) begin
      stop = vecs[i].stop;
      step(vecs[i].edges);
      check_time($sformatf("vec%0d", i), vecs[i].hour, vecs[i].min, vecs[i].sec);
      check($sformatf("vec%0d ring", i), int'(ring), vecs[i].ring);
    end
    stop = 1'b0;

    // Jump to 23:59:59 and land a capture on the wrapping tick.
    step(9);
    check_time("pre_force", 1, 0, 1);
    check("pre_force presc", int'(dut.presc_q), 0);
    force dut.time_d = T_LAST;
    step(1);
    release dut.time_d;
    check_time("forced", 23, 59, 59);
    step(6);
    pulse_record();
    step(2);
    check_time("pre_wrap", 23, 59, 59);
    check("pre_wrap ring", int'(ring), 0);
    check("pre_wrap rec_sec", int'(rec_sec), 3);
    step(1);
    check_time("wrap", 0, 0, 0);
    check("wrap ring", int'(ring), RING_ON);
    check("wrap rec_hour", int'(rec_hour), 23);
    check("wrap rec_min", int'(rec_min), 59);
    check("wrap rec_sec", int'(rec_sec), 59);
    step(1);
    check("post_wrap ring", int'(ring), 0);
    check("post_wrap sec", int'(sec), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
